// File: rtl/timer_capture.sv
`default_nettype none
// ============================================================================
// Module   : timer_capture
// Purpose  : Timestamps rising edges of an asynchronous event line against a
//            free-running 8-bit timer and queues {stamp, delta, first} in a
//            small FIFO drained through a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module timer_capture #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [7:0]               timer_val,
   input  logic                     event_in,
   input  logic                     cap_ready,
   input  logic                     clr,
   output logic                     cap_valid,
   output logic [7:0]               cap_stamp,
   output logic [7:0]               cap_delta,
   output logic                     cap_first,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] C_FULL = LW'(DEPTH);

   // Synchronizer chain and registered edge strobe
   logic          sync1_q, sync2_q, sync3_q, strobe_q;

   // FIFO control state
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    prev_q, prev_d;
   logic          first_q, first_d;

   // FIFO storage
   logic [7:0]    mem_stamp_q [DEPTH];
   logic [7:0]    mem_delta_q [DEPTH];
   logic          mem_first_q [DEPTH];

   logic          full_w, pop_w, push_w, wr_en_w;
   logic [7:0]    delta_w;

   // Two-flop synchronizer, third stage for edge detect, strobe register.
   // Keeps running during clr; only resetn clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sync3_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         sync1_q  <= event_in;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
         strobe_q <= sync2_q & ~sync3_q;
      end
   end

   assign full_w  = (level_q == C_FULL);
   assign pop_w   = cap_valid & cap_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign push_w  = strobe_q & (~full_w | pop_w);
   assign wr_en_w = push_w & ~clr;
   assign delta_w = timer_val - prev_q;

   // Next-state for pointers, occupancy, overflow flag and previous stamp
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      prev_d  = prev_q;
      first_d = first_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         prev_d  = 8'h00;
         first_d = 1'b1;
      end else begin
         if (push_w) begin
            wptr_d  = wptr_q + 1'b1;
            prev_d  = timer_val;
            first_d = 1'b0;
         end
         if (pop_w) begin
            rptr_d = rptr_q + 1'b1;
         end
         case ({push_w, pop_w})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         if (strobe_q && full_w && !pop_w) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         prev_q  <= 8'h00;
         first_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         prev_q  <= prev_d;
         first_q <= first_d;
      end
   end

   // FIFO storage write; contents are masked at the output when empty
   always_ff @(posedge clk) begin
      if (wr_en_w) begin
         mem_stamp_q[wptr_q] <= timer_val;
         mem_delta_q[wptr_q] <= delta_w;
         mem_first_q[wptr_q] <= first_q;
      end
   end

   assign cap_valid = (level_q != '0);
   assign cap_stamp = cap_valid ? mem_stamp_q[rptr_q] : 8'h00;
   assign cap_delta = cap_valid ? mem_delta_q[rptr_q] : 8'h00;
   assign cap_first = cap_valid ? mem_first_q[rptr_q] : 1'b0;
   assign ovf       = ovf_q;
   assign level     = level_q;

endmodule
`default_nettype wire
